// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Owns the program counter, issues word-aligned requests to instruction memory,
// buffers in-order responses together with their PC and hands them to decode.
// Redirects from execute flush everything younger than the redirect and restart
// fetch; responses to requests issued before the redirect are counted and dropped.
//
// Build option: define FETCH_BYPASS_EN to let a response reach decode in the same
// cycle when the instruction buffer is empty and nothing is being dropped.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both 1. The request channel holds its
// valid until it is accepted unless a redirect withdraws it. The response channel
// has no ready: responses arrive in request order and are always taken.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [SW-1:0] DEPTH_S   = SW'(DEPTH);
  localparam logic [31:0]   INSTR_NOP = 32'h0000_0013;

  // Next fetch address.
  logic [31:0]   pc_q;

  // Instruction buffer: {instr, pc} entries between memory and decode.
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] buf_rd_ptr;
  logic [PW-1:0] buf_wr_ptr;
  logic [CW-1:0] count;

  // Addresses of accepted requests whose responses are still due.
  logic [31:0]   pend_pc [DEPTH];
  logic [PW-1:0] pend_rd_ptr;
  logic [PW-1:0] pend_wr_ptr;
  logic [CW-1:0] inflight;

  // Responses still owed to requests issued before a redirect.
  logic [CW-1:0] drop;

  logic          buf_empty;
  logic          rsp_live;
  logic          bypass;
  logic          pop;
  logic          buf_push;
  logic          buf_pop;
  logic          req_fire;
  logic          credit_ok;
  logic [SW-1:0] occupancy;

  // The two low redirect address bits are architecturally ignored.
  logic          unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign imem_req_addr = pc_q;

  // Control: response classification, bypass, credit check and request valid.
  always_comb begin
    buf_empty = (count == '0);
    // A response is kept only if nothing stale is still owed and no redirect is
    // flushing this cycle; a response in the redirect cycle is already stale.
    rsp_live  = imem_rsp_valid & (drop == '0) & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
    bypass    = rst_n & rsp_live & buf_empty;
`else
    bypass    = 1'b0;
`endif
    pop       = id_ready & (~buf_empty | bypass);
    buf_pop   = id_ready & ~buf_empty;
    // A bypassed response that decode takes immediately never enters the buffer.
    buf_push  = rsp_live & ~(bypass & id_ready);
    // Every issued request owns a buffer slot until decode takes it; stale
    // requests keep their slot until their response has been discarded.
    occupancy = SW'(inflight) + SW'(drop) + SW'(count) - SW'(pop);
    credit_ok = (occupancy < DEPTH_S);
    imem_req_valid = rst_n & ~redirect_valid & credit_ok;
    req_fire  = imem_req_valid & imem_req_ready;
  end

  // Program counter: redirect wins, otherwise advance by one word per accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= {redirect_pc[31:2], 2'b00};
    end else if (req_fire) begin
      pc_q <= pc_q + 32'd4;
    end
  end

  // Pending-PC queue: push on request acceptance, pop on a kept response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_rd_ptr <= '0;
      pend_wr_ptr <= '0;
    end else if (redirect_valid) begin
      pend_rd_ptr <= '0;
      pend_wr_ptr <= '0;
    end else begin
      if (req_fire) begin
        pend_pc[pend_wr_ptr] <= pc_q;
        pend_wr_ptr          <= pend_wr_ptr + PTR_ONE;
      end
      if (rsp_live) begin
        pend_rd_ptr <= pend_rd_ptr + PTR_ONE;
      end
    end
  end

  // Instruction buffer: write kept responses, advance head on decode handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_rd_ptr <= '0;
      buf_wr_ptr <= '0;
      count      <= '0;
    end else if (redirect_valid) begin
      buf_rd_ptr <= '0;
      buf_wr_ptr <= '0;
      count      <= '0;
    end else begin
      if (buf_push) begin
        buf_instr[buf_wr_ptr] <= imem_rsp_data;
        buf_pc[buf_wr_ptr]    <= pend_pc[pend_rd_ptr];
        buf_wr_ptr            <= buf_wr_ptr + PTR_ONE;
      end
      if (buf_pop) begin
        buf_rd_ptr <= buf_rd_ptr + PTR_ONE;
      end
      if (buf_push && !buf_pop) begin
        count <= count + CNT_ONE;
      end else if (!buf_push && buf_pop) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // Outstanding and stale response counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Everything in flight becomes stale, less a response consumed right now.
      inflight <= '0;
      drop     <= drop + inflight - CW'(imem_rsp_valid);
    end else begin
      if (req_fire && !rsp_live) begin
        inflight <= inflight + CNT_ONE;
      end else if (!req_fire && rsp_live) begin
        inflight <= inflight - CNT_ONE;
      end
      if (imem_rsp_valid && (drop != '0)) begin
        drop <= drop - CNT_ONE;
      end
    end
  end

  // Decode outputs: buffer head, else the bypassed response, else a NOP with pc 0.
  always_comb begin
    id_valid = 1'b0;
    id_instr = INSTR_NOP;
    id_pc    = '0;
    if (!buf_empty) begin
      id_valid = 1'b1;
      id_instr = buf_instr[buf_rd_ptr];
      id_pc    = buf_pc[buf_rd_ptr];
    end
`ifdef FETCH_BYPASS_EN
    else if (bypass) begin
      id_valid = 1'b1;
      id_instr = imem_rsp_data;
      id_pc    = pend_pc[pend_rd_ptr];
    end
`endif
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with an in-order memory model
// of configurable latency and an expected-PC scoreboard for decode.
module tb_fetch_stage;

  localparam int          DEPTH     = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0100;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int          RSP_TO_ID = 0;
`else
  localparam int          RSP_TO_ID = 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  // ---------------- model state ----------------
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          mem_lat    = 1;
  int          epoch      = 0;
  logic [31:0] mq_addr  [$];
  int          mq_due   [$];
  int          mq_epoch [$];
  logic [31:0] exp_q    [$];
  logic [31:0] pop_log  [$];
  logic [31:0] exp_req_pc = RESET_PC;
  int          n_pop           = 0;
  int          first_req_cyc   = -1;
  int          first_valid_cyc = -1;
  int          redirect_cyc    = 0;
  logic        prev_hold       = 1'b0;
  logic        prev_redirect   = 1'b0;
  logic [31:0] prev_pc         = '0;
  logic [31:0] prev_instr      = '0;
  logic        cyc_rsp         = 1'b0;
  logic        cyc_pop         = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Caller sets id_ready / imem_req_ready / redirect_* before calling.
  task automatic cycle();
    int stale;
    stale = 0;
    foreach (mq_epoch[i]) if (mq_epoch[i] != epoch) stale++;
    check("credit_cap", 32'(exp_q.size() + stale <= DEPTH), 32'd1);

    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      void'(mq_epoch.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    cyc_rsp = imem_rsp_valid;
    cyc_pop = id_valid & id_ready;

    if (!id_valid) begin
      check("idle_instr", id_instr, INSTR_NOP);
      check("idle_pc", id_pc, 32'd0);
    end
    if (prev_redirect) check("valid_after_redirect", 32'(id_valid), 32'd0);
    if (prev_hold) begin
      check("hold_valid", 32'(id_valid), 32'd1);
      check("hold_pc", id_pc, prev_pc);
      check("hold_instr", id_instr, prev_instr);
    end
    if (redirect_valid) check("req_during_redirect", 32'(imem_req_valid), 32'd0);

    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req_pc);
      if (first_req_cyc < 0) first_req_cyc = cyc;
      mq_addr.push_back(imem_req_addr);
      mq_due.push_back(cyc + mem_lat);
      mq_epoch.push_back(epoch);
      exp_q.push_back(exp_req_pc);
      exp_req_pc = exp_req_pc + 32'd4;
    end

    if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (id_valid && id_ready) begin
      n_pop++;
      pop_log.push_back(id_pc);
      compared++;
      assert (exp_q.size() > 0) else begin
        mismatched++;
        $error("FAIL pop_unexpected: observed pc %h expected no instruction", id_pc);
      end
      if (exp_q.size() > 0) begin
        check("pop_pc", id_pc, exp_q[0]);
        check("pop_instr", id_instr, instr_of(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end

    prev_hold     = id_valid & ~id_ready & ~redirect_valid;
    prev_pc       = id_pc;
    prev_instr    = id_instr;
    prev_redirect = redirect_valid;
    if (redirect_valid) begin
      epoch++;
      exp_q.delete();
      pop_log.delete();
      exp_req_pc      = {redirect_pc[31:2], 2'b00};
      first_valid_cyc = -1;
      redirect_cyc    = cyc;
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_id_instr", id_instr, INSTR_NOP);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);

    // 1: reset release, 1-cycle memory, decode always ready
    rst_n          = 1'b1;
    cyc            = 0;
    imem_req_ready = 1'b1;
    id_ready       = 1'b1;
    mem_lat        = 1;
    repeat (10) cycle();
    check("first_req_cycle", 32'(first_req_cyc), 32'd0);
    check("first_valid_cycle", 32'(first_valid_cyc), 32'(1 + RSP_TO_ID));
    check("sustained_pops", 32'(n_pop), 32'(10 - 1 - RSP_TO_ID));

    // 2: decode stalls for 5 cycles, then releases
    id_ready = 1'b0;
    repeat (5) cycle();
    check("stall_fill", 32'(exp_q.size()), 32'(DEPTH));
    id_ready = 1'b1;
    repeat (6) cycle();

    // 3: redirect to 0x2002 with two requests in flight
    mem_lat = 3;
    repeat (6) cycle();
    for (int i = 0; i < 10 && mq_addr.size() != 2; i++) cycle();
    check("two_in_flight", 32'(mq_addr.size()), 32'd2);
    do_redirect(32'h0000_2002);
    for (int i = 0; i < 40 && pop_log.size() == 0; i++) cycle();
    check("redir_got_pop", 32'(pop_log.size() > 0), 32'd1);
    if (pop_log.size() > 0) check("redir_first_pc", pop_log[0], 32'h0000_2000);

    // 4: redirect coinciding with a response and a decode handshake
    mem_lat = 1;
    repeat (6) cycle();
    do_redirect(32'h0000_3000);
    check("redir_cycle_rsp", 32'(cyc_rsp), 32'd1);
    check("redir_cycle_pop", 32'(cyc_pop), 32'd1);
    repeat (8) cycle();
    check("redir_latency", 32'(first_valid_cyc - redirect_cyc), 32'(2 + RSP_TO_ID));

    // 5: address wrap at the top of the address space
    do_redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 40 && pop_log.size() < 3; i++) cycle();
    check("wrap_pops", 32'(pop_log.size() >= 3), 32'd1);
    if (pop_log.size() >= 3) begin
      check("wrap_pc0", pop_log[0], 32'hFFFF_FFFC);
      check("wrap_pc1", pop_log[1], 32'h0000_0000);
      check("wrap_pc2", pop_log[2], 32'h0000_0004);
    end

    // 6: random request backpressure, 3-cycle memory, 1000 instructions
    mem_lat = 3;
    base    = n_pop;
    for (int i = 0; i < 20000 && (n_pop - base) < 1000; i++) begin
      imem_req_ready = ($urandom_range(0, 1) == 1);
      id_ready       = ($urandom_range(0, 3) != 0);
      if (i == 300) begin
        do_redirect(32'h0000_4000);
      end else begin
        cycle();
      end
    end
    check("random_progress", 32'((n_pop - base) >= 1000), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
